// File: rtl/beep_sequencer.sv
// rtl/beep_sequencer.sv - turns answer/foul/timeout events into timed beep envelopes on beep_en
// Optional BEEP_PREEMPT_EN: a strictly higher-priority event aborts and replaces the running pattern.
module beep_sequencer #(
    parameter int TICK_DIV     = 100_000,
    parameter int SHORT_MS     = 100,
    parameter int LONG_MS      = 1000,
    parameter int GAP_MS       = 100,
    parameter int FOUL_REPEATS = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic answer_evt,
    input  logic foul_evt,
    input  logic timeout_evt,
    output logic beep_en,
    output logic busy
);

    localparam int PH_MAX0 = (SHORT_MS > LONG_MS) ? SHORT_MS : LONG_MS;
    localparam int PH_MAX  = (PH_MAX0 > GAP_MS) ? PH_MAX0 : GAP_MS;
    localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PH_W    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int REP_W   = (FOUL_REPEATS > 1) ? $clog2(FOUL_REPEATS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [PH_W-1:0]  SHORT_LAST = PH_W'(SHORT_MS - 1);
    localparam logic [PH_W-1:0]  LONG_LAST  = PH_W'(LONG_MS - 1);
    localparam logic [PH_W-1:0]  GAP_LAST   = PH_W'(GAP_MS - 1);
    localparam logic [REP_W-1:0] REP_LAST   = REP_W'(FOUL_REPEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             long_q, long_d;
    logic             multi_q, multi_d;
    logic             beep_en_q, beep_en_d;
    logic             busy_q, busy_d;

    logic             any_evt;
    logic             tick;
    logic             phase_done;
    logic             start;
    logic [PH_W-1:0]  phase_last;

`ifdef BEEP_PREEMPT_EN
    logic [1:0] evt_prio;
    logic [1:0] cur_prio;
    assign evt_prio = timeout_evt ? 2'd2 : (foul_evt ? 2'd1 : 2'd0);
    assign cur_prio = long_q ? 2'd2 : (multi_q ? 2'd1 : 2'd0);
`endif

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        phase_d    = phase_q;
        rep_d      = rep_q;
        long_d     = long_q;
        multi_d    = multi_q;
        start      = 1'b0;
        any_evt    = answer_evt | foul_evt | timeout_evt;
        tick       = (div_q == DIV_LAST);
        phase_last = (state_q == S_GAP) ? GAP_LAST : (long_q ? LONG_LAST : SHORT_LAST);
        phase_done = tick && (phase_q == phase_last);

        if (state_q == S_IDLE) begin
            start = any_evt;
        end else begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
                phase_d = phase_done ? '0 : phase_q + 1'b1;
            end
            if (phase_done) begin
                if (state_q == S_GAP) begin
                    state_d = S_ON;
                end else if (multi_q && (rep_q != REP_LAST)) begin
                    state_d = S_GAP;
                    rep_d   = rep_q + 1'b1;
                end else begin
                    // Pattern complete; an event on this same edge is deliberately dropped.
                    state_d = S_IDLE;
                    rep_d   = '0;
                    long_d  = 1'b0;
                    multi_d = 1'b0;
                end
            end
`ifdef BEEP_PREEMPT_EN
            if (any_evt && (evt_prio > cur_prio)) begin
                start = 1'b1;
            end
`endif
        end

        if (start) begin
            state_d = S_ON;
            div_d   = '0;
            phase_d = '0;
            rep_d   = '0;
            long_d  = timeout_evt;
            multi_d = foul_evt & ~timeout_evt;
        end

        beep_en_d = (state_d == S_ON);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            phase_q   <= '0;
            rep_q     <= '0;
            long_q    <= 1'b0;
            multi_q   <= 1'b0;
            beep_en_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            phase_q   <= phase_d;
            rep_q     <= rep_d;
            long_q    <= long_d;
            multi_q   <= multi_d;
            beep_en_q <= beep_en_d;
            busy_q    <= busy_d;
        end
    end

    assign beep_en = beep_en_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_beep_sequencer.sv
// tb/tb_beep_sequencer.sv - directed self-checking bench for beep_sequencer
module tb_beep_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic answer_evt, foul_evt, timeout_evt;
    logic beep_en, busy;

    int checks = 0;
    int errors = 0;

    logic be_log   [0:255];
    logic busy_log [0:255];
    int   runs[$];
    int   on_total;
    int   busy_total;
    int   exp_pre;

    always #5 clk = ~clk;

    beep_sequencer #(
        .TICK_DIV    (10),
        .SHORT_MS    (3),
        .LONG_MS     (8),
        .GAP_MS      (2),
        .FOUL_REPEATS(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .answer_evt (answer_evt),
        .foul_evt   (foul_evt),
        .timeout_evt(timeout_evt),
        .beep_en    (beep_en),
        .busy       (busy)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one-cycle event pulse from a negedge; returns on the following negedge.
    task automatic pulse(input logic a, input logic f, input logic t);
        answer_evt  = a;
        foul_evt    = f;
        timeout_evt = t;
        @(negedge clk);
        answer_evt  = 1'b0;
        foul_evt    = 1'b0;
        timeout_evt = 1'b0;
    endtask

    // Record n negedge samples; optionally inject a one-cycle event/reset after sample inj_at.
    task automatic capture(input int n, input int inj_at,
                           input logic ia, input logic if_, input logic it, input logic ir);
        for (int i = 0; i < n; i++) begin
            be_log[i]   = beep_en;
            busy_log[i] = busy;
            answer_evt  = (i == inj_at) ? ia  : 1'b0;
            foul_evt    = (i == inj_at) ? if_ : 1'b0;
            timeout_evt = (i == inj_at) ? it  : 1'b0;
            rst         = (i == inj_at) ? ir  : 1'b0;
            @(negedge clk);
        end
        answer_evt  = 1'b0;
        foul_evt    = 1'b0;
        timeout_evt = 1'b0;
        rst         = 1'b0;
    endtask

    task automatic analyze(input int n);
        logic cur;
        int   len;
        runs.delete();
        on_total   = 0;
        busy_total = 0;
        cur        = be_log[0];
        len        = 0;
        for (int i = 0; i < n; i++) begin
            on_total   += int'(be_log[i]);
            busy_total += int'(busy_log[i]);
            if (be_log[i] == cur) begin
                len++;
            end else begin
                runs.push_back(len);
                cur = be_log[i];
                len = 1;
            end
        end
        runs.push_back(len);
    endtask

    function automatic int run_at(input int k);
        return (runs.size() > k) ? runs[k] : -1;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        answer_evt  = 1'b0;
        foul_evt    = 1'b0;
        timeout_evt = 1'b0;
        @(negedge clk);

        // Reset held with all events asserted
        answer_evt  = 1'b1;
        foul_evt    = 1'b1;
        timeout_evt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_beep_en", int'(beep_en), 0);
            check("rst_busy", int'(busy), 0);
        end
        rst         = 1'b0;
        answer_evt  = 1'b0;
        foul_evt    = 1'b0;
        timeout_evt = 1'b0;
        idle(2);
        check("idle_beep_en", int'(beep_en), 0);

        // ANSWER: 30 cycles on, starting the cycle after the pulse
        pulse(1'b1, 1'b0, 1'b0);
        capture(60, -1, 1'b0, 1'b0, 1'b0, 1'b0);
        analyze(60);
        check("ans_latency", int'(be_log[0]), 1);
        check("ans_on_len", run_at(0), 30);
        check("ans_on_total", on_total, 30);
        check("ans_busy_total", busy_total, 30);
        check("ans_busy_fall", int'(busy_log[30]), 0);

        // FOUL: 30/20/30/20/30, busy 130 cycles
        pulse(1'b0, 1'b1, 1'b0);
        capture(200, -1, 1'b0, 1'b0, 1'b0, 1'b0);
        analyze(200);
        check("foul_on1", run_at(0), 30);
        check("foul_gap1", run_at(1), 20);
        check("foul_on2", run_at(2), 30);
        check("foul_gap2", run_at(3), 20);
        check("foul_on3", run_at(4), 30);
        check("foul_on_total", on_total, 90);
        check("foul_busy_total", busy_total, 130);
        check("foul_busy_last", int'(busy_log[129]), 1);
        check("foul_busy_fall", int'(busy_log[130]), 0);

        // Simultaneous answer + timeout: only the long beep
        pulse(1'b1, 1'b0, 1'b1);
        capture(120, -1, 1'b0, 1'b0, 1'b0, 1'b0);
        analyze(120);
        check("simul_on_len", run_at(0), 80);
        check("simul_on_total", on_total, 80);
        check("simul_busy_total", busy_total, 80);

        // Answer during running timeout is ignored
        pulse(1'b0, 1'b0, 1'b1);
        capture(120, 20, 1'b1, 1'b0, 1'b0, 1'b0);
        analyze(120);
        check("ans_in_to_on_len", run_at(0), 80);
        check("ans_in_to_on_total", on_total, 80);

        // Timeout at cycle 15 of an answer
`ifdef BEEP_PREEMPT_EN
        exp_pre = 95;
`else
        exp_pre = 30;
`endif
        pulse(1'b1, 1'b0, 1'b0);
        capture(120, 14, 1'b0, 1'b0, 1'b1, 1'b0);
        analyze(120);
        check("preempt_on_len", run_at(0), exp_pre);
        check("preempt_on_total", on_total, exp_pre);

        // Event on the edge that returns to IDLE is dropped
        pulse(1'b1, 1'b0, 1'b0);
        capture(60, 29, 1'b1, 1'b0, 1'b0, 1'b0);
        analyze(60);
        check("end_edge_on_total", on_total, 30);
        check("end_edge_busy_after", int'(busy_log[31]), 0);

        // Earliest re-trigger one cycle later is accepted
        pulse(1'b1, 1'b0, 1'b0);
        capture(80, 30, 1'b1, 1'b0, 1'b0, 1'b0);
        analyze(80);
        check("retrig_gap", run_at(1), 1);
        check("retrig_on_total", on_total, 60);

        // Reset pulse at cycle 40 of FOUL abandons the pattern
        pulse(1'b0, 1'b1, 1'b0);
        capture(100, 39, 1'b0, 1'b0, 1'b0, 1'b1);
        analyze(100);
        check("foul_rst_busy_before", int'(busy_log[39]), 1);
        check("foul_rst_busy_after", int'(busy_log[40]), 0);
        check("foul_rst_beep_after", int'(be_log[40]), 0);
        check("foul_rst_on_total", on_total, 30);

        pulse(1'b1, 1'b0, 1'b0);
        capture(60, -1, 1'b0, 1'b0, 1'b0, 1'b0);
        analyze(60);
        check("post_rst_ans_latency", int'(be_log[0]), 1);
        check("post_rst_ans_on_len", run_at(0), 30);
        check("post_rst_ans_busy", busy_total, 30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
